// File: rtl/mem_stage.sv
// mem_stage: MIPS memory stage; registers the execute bus, aligns load data, forwards the result and holds stalled load data.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 80,
  parameter int MEM_TO_WB_WD = 70
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [5:0]              stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [64:0]             ex_to_mem_hilo,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_to_id,
  output logic [64:0]             mem_to_wb_hilo
);
  logic [EX_TO_MEM_WD-1:0] bus_r;
  logic [64:0] hilo_r;
  logic [31:0] rdata_hold;
  logic hold_valid;
  logic [3:0] ram_op;
  logic [31:0] pc, ex_result, w, rf_wdata, load_res;
  logic sel_rf_res, rf_we;
  logic [4:0] rf_waddr;
  logic [1:0] a;
  logic [7:0] b;
  logic [15:0] h;
  logic unused;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      bus_r <= '0;
      hilo_r <= '0;
      rdata_hold <= '0;
      hold_valid <= 1'b0;
    end else begin
      if (!stall[3]) begin
        bus_r <= ex_to_mem_bus;
        hilo_r <= ex_to_mem_hilo;
      end else if (!stall[4]) begin
        bus_r <= '0;
        hilo_r <= '0;
      end
      // Only the first held edge captures; the SRAM word may change afterwards.
      if (stall[3] && stall[4]) begin
        if (!hold_valid) begin
          rdata_hold <= data_sram_rdata;
          hold_valid <= 1'b1;
        end
      end else
        hold_valid <= 1'b0;
    end
  always_comb begin
    ram_op = bus_r[79:76];
    pc = bus_r[75:44];
    sel_rf_res = bus_r[38];
    rf_we = bus_r[37];
    rf_waddr = bus_r[36:32];
    ex_result = bus_r[31:0];
    a = ex_result[1:0];
    w = hold_valid ? rdata_hold : data_sram_rdata;
    b = a == 2'd0 ? w[7:0] : a == 2'd1 ? w[15:8] : a == 2'd2 ? w[23:16] : w[31:24];
    h = a[1] ? w[31:16] : w[15:0];
    load_res = ram_op == 4'b0001 ? {{24{b[7]}}, b} :
               ram_op == 4'b0010 ? {24'd0, b} :
               ram_op == 4'b0011 ? {{16{h[15]}}, h} :
               ram_op == 4'b0100 ? {16'd0, h} : w;
    rf_wdata = sel_rf_res ? load_res : ex_result;
    mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
    mem_to_id = {rf_we && rf_waddr != 5'd0, rf_waddr, rf_wdata};
    mem_to_wb_hilo = hilo_r;
    unused = ^{stall[5], stall[2:0], bus_r[43:39]};
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of load alignment, stall hold, bubble, forwarding and async reset.
module tb_mem_stage;
  logic clk = 1'b0, resetn = 1'b0;
  logic [5:0] stall = '0;
  logic [79:0] ex_to_mem_bus = '0;
  logic [64:0] ex_to_mem_hilo = '0;
  logic [31:0] data_sram_rdata = '0;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_id;
  logic [64:0] mem_to_wb_hilo;
  int checks = 0, failures = 0;
  mem_stage dut (
    .clk(clk), .resetn(resetn), .stall(stall), .ex_to_mem_bus(ex_to_mem_bus),
    .ex_to_mem_hilo(ex_to_mem_hilo), .data_sram_rdata(data_sram_rdata),
    .mem_to_wb_bus(mem_to_wb_bus), .mem_to_id(mem_to_id), .mem_to_wb_hilo(mem_to_wb_hilo)
  );
  always #5 clk = ~clk;
  function automatic logic [79:0] mk(input logic [3:0] op, input logic [31:0] pc,
                                     input logic sel, input logic we, input logic [4:0] wa,
                                     input logic [31:0] res);
    return {op, pc, 1'b1, 4'd0, sel, we, wa, res};
  endfunction
  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [79:0] bus, input logic [5:0] st, input logic [31:0] rd);
    @(negedge clk);
    ex_to_mem_bus = bus;
    stall = st;
    data_sram_rdata = rd;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #12;
    chk("reset_wb", 80'(mem_to_wb_bus), 80'd0);
    chk("reset_id", 80'(mem_to_id), 80'd0);
    chk("reset_hilo", 80'(mem_to_wb_hilo), 80'd0);
    @(negedge clk);
    resetn = 1'b1;
    ex_to_mem_hilo = {1'b1, 32'h11112222, 32'h33334444};
    step(mk(4'hF, 32'hBFC00010, 1, 1, 5'd8, 32'h100), 6'd0, 32'hDEADBEEF);
    chk("lw_wb", 80'(mem_to_wb_bus), 80'({32'hBFC00010, 1'b1, 5'd8, 32'hDEADBEEF}));
    chk("lw_id", 80'(mem_to_id), 80'({1'b1, 5'd8, 32'hDEADBEEF}));
    chk("hilo_pass", 80'(mem_to_wb_hilo), 80'({1'b1, 32'h11112222, 32'h33334444}));
    step(mk(4'h1, 32'h4, 1, 1, 5'd9, 32'h102), 6'd0, 32'h8070F0A5);
    chk("lb_a2", 80'(mem_to_id[31:0]), 80'h00000070);
    step(mk(4'h1, 32'h8, 1, 1, 5'd9, 32'h103), 6'd0, 32'h8070F0A5);
    chk("lb_a3", 80'(mem_to_id[31:0]), 80'hFFFFFF80);
    step(mk(4'h2, 32'hC, 1, 1, 5'd9, 32'h103), 6'd0, 32'h8070F0A5);
    chk("lbu_a3", 80'(mem_to_id[31:0]), 80'h00000080);
    step(mk(4'h3, 32'h10, 1, 1, 5'd9, 32'h100), 6'd0, 32'h8070F0A5);
    chk("lh_a0", 80'(mem_to_id[31:0]), 80'hFFFFF0A5);
    step(mk(4'h4, 32'h14, 1, 1, 5'd9, 32'h102), 6'd0, 32'h8070F0A5);
    chk("lhu_a2", 80'(mem_to_id[31:0]), 80'h00008070);
    step(mk(4'h3, 32'h18, 1, 1, 5'd9, 32'h103), 6'd0, 32'h8070F0A5);
    chk("lh_misaligned", 80'(mem_to_id[31:0]), 80'hFFFF8070);
    step(mk(4'hF, 32'h20, 1, 1, 5'd10, 32'h200), 6'd0, 32'hCAFEF00D);
    chk("stall_entry", 80'(mem_to_wb_bus[31:0]), 80'hCAFEF00D);
    step(mk(4'hF, 32'h24, 1, 1, 5'd11, 32'h300), 6'b011000, 32'hCAFEF00D);
    data_sram_rdata = 32'h12345678;
    #1;
    chk("stall_1", 80'(mem_to_wb_bus), 80'({32'h20, 1'b1, 5'd10, 32'hCAFEF00D}));
    step(mk(4'hF, 32'h24, 1, 1, 5'd11, 32'h300), 6'b011000, 32'h12345678);
    chk("stall_2", 80'(mem_to_wb_bus[31:0]), 80'hCAFEF00D);
    step(mk(4'hF, 32'h24, 1, 1, 5'd11, 32'h300), 6'b011000, 32'h12345678);
    chk("stall_3", 80'(mem_to_wb_bus[31:0]), 80'hCAFEF00D);
    @(negedge clk);
    stall = 6'd0;
    #1;
    chk("stall_release", 80'(mem_to_wb_bus[31:0]), 80'hCAFEF00D);
    step(mk(4'hF, 32'h28, 1, 1, 5'd12, 32'h400), 6'd0, 32'h55AA55AA);
    chk("after_release", 80'(mem_to_wb_bus[31:0]), 80'h55AA55AA);
    step(mk(4'hF, 32'h2C, 1, 1, 5'd12, 32'h400), 6'b001000, 32'h55AA55AA);
    chk("bubble_wb", 80'(mem_to_wb_bus), 80'd0);
    chk("bubble_hilo_we", 80'(mem_to_wb_hilo[64]), 80'd0);
    step(mk(4'h0, 32'h30, 0, 1, 5'd0, 32'h42), 6'd0, 32'hFFFFFFFF);
    chk("alu_wb", 80'(mem_to_wb_bus), 80'({32'h30, 1'b1, 5'd0, 32'h42}));
    chk("alu_id_r0", 80'(mem_to_id), 80'({1'b0, 5'd0, 32'h42}));
    step(mk(4'h0, 32'h34, 0, 1, 5'd3, 32'h77), 6'd0, 32'hFFFFFFFF);
    chk("alu_id_r3", 80'(mem_to_id), 80'({1'b1, 5'd3, 32'h77}));
    step(mk(4'h2, 32'h38, 1, 1, 5'd4, 32'h501), 6'd0, 32'h0000BB00);
    step(mk(4'hF, 32'h3C, 1, 1, 5'd4, 32'h600), 6'b011000, 32'h0000BB00);
    data_sram_rdata = 32'h0;
    #1;
    chk("hold_before_reset", 80'(mem_to_wb_bus[31:0]), 80'h000000BB);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_rst_wb", 80'(mem_to_wb_bus), 80'd0);
    chk("async_rst_id", 80'(mem_to_id), 80'd0);
    chk("async_rst_hilo", 80'(mem_to_wb_hilo), 80'd0);
    @(negedge clk);
    resetn = 1'b1;
    step(mk(4'h2, 32'h40, 1, 1, 5'd5, 32'h501), 6'd0, 32'h00001100);
    chk("post_reset_live", 80'(mem_to_wb_bus), 80'({32'h40, 1'b1, 5'd5, 32'h00000011}));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
